// File: rtl/inst_mem_ctrl.sv
// rtl/inst_mem_ctrl.sv - instruction memory with boot clear sweep, load port and one-cycle fetch port
// Define INST_MEM_CLEAR_EN to zero every word after reset before the fetch port opens.
module inst_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic                  inst_fault,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ack,
  output logic                  load_err,
  output logic                  init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]            r_state;
  logic [IDX_W-1:0]      w_fetch_idx;
  logic [IDX_W-1:0]      w_load_idx;
  logic                  w_fetch_legal;
  logic                  w_load_legal;
  logic                  w_fetch_go;
  logic                  w_load_go;

  // DEPTH is a power of two, so "index < DEPTH" means all bits above the index are zero
  assign w_fetch_idx   = fetch_addr[IDX_W+1:2];
  assign w_load_idx    = load_addr[IDX_W+1:2];
  assign w_fetch_legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign w_load_legal  = (load_addr[1:0] == 2'b00) && (load_addr[ADDR_WIDTH-1:IDX_W+2] == '0);

  assign fetch_ready = (r_state == S_READY) && !load_en;
  assign w_fetch_go  = fetch_req && fetch_ready;
  assign w_load_go   = load_en && (r_state == S_READY);
  assign init_done   = (r_state == S_READY);

`ifdef INST_MEM_CLEAR_EN
  logic [IDX_W-1:0] r_clr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + IDX_W'(1);
      if (r_clr_cnt == IDX_W'(DEPTH - 1)) begin
        r_state <= S_READY;
      end
    end
  end

  // Storage has no reset; the sweep is what zeroes it
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_load_go && w_load_legal) begin
      r_mem[w_load_idx] <= load_data;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_READY;
    end else begin
      r_state <= S_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_go && w_load_legal) begin
      r_mem[w_load_idx] <= load_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_valid <= 1'b0;
      inst_fault <= 1'b0;
      inst_out   <= '0;
      load_ack   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      inst_valid <= w_fetch_go;
      inst_fault <= w_fetch_go && !w_fetch_legal;
      if (w_fetch_go) begin
        inst_out <= w_fetch_legal ? r_mem[w_fetch_idx] : NOP_WORD;
      end
      load_ack <= w_load_go && w_load_legal;
      load_err <= w_load_go && !w_load_legal;
    end
  end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb/tb_inst_mem_ctrl.sv - scoreboard bench for inst_mem_ctrl (clear sweep, load, fetch, faults, reset)
module tb_inst_mem_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 32;

  logic          clk;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          inst_valid;
  logic [DW-1:0] inst_out;
  logic          inst_fault;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_ack;
  logic          load_err;
  logic          init_done;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          fault;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            checks   = 0;
  int            failures = 0;

  inst_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_fault (inst_fault),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ack   (load_ack),
    .load_err   (load_err),
    .init_done  (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every inst_valid pops one expected result
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (inst_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: inst_valid=1 inst_out=%h with nothing expected", inst_out);
        end else begin
          e = sb.pop_front();
          if (inst_out !== e.data || inst_fault !== e.fault) begin
            failures++;
            $display("FAIL sb_fetch: got data=%h fault=%b expected data=%h fault=%b",
                     inst_out, inst_fault, e.data, e.fault);
          end
        end
      end else if (inst_fault !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL fault_idle: inst_fault=%b expected 0 without inst_valid", inst_fault);
      end
    end
  end

  function automatic exp_t expect_fetch(input logic [31:0] a);
    exp_t e;
    if (a[1:0] == 2'b00 && (a >> 2) < DEPTH) begin
      e.data  = model[a[7:2]];
      e.fault = 1'b0;
    end else begin
      e.data  = 32'h0000_0013;
      e.fault = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    sb.push_back(expect_fetch(a));
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en = 1'b0;
    if (a[1:0] == 2'b00 && (a >> 2) < DEPTH) model[a[7:2]] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    logic exp_init;
`ifdef INST_MEM_CLEAR_EN
    exp_init = 1'b0;
`else
    exp_init = 1'b1;
`endif
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({inst_valid, inst_fault, load_ack, load_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected 0000", {inst_valid, inst_fault, load_ack, load_err});
    end
    checks++;
    if (inst_out !== '0) begin
      failures++;
      $display("FAIL reset_inst_out: got %h expected 0", inst_out);
    end
    checks++;
    if (init_done !== exp_init) begin
      failures++;
      $display("FAIL reset_init_done: got %b expected %b", init_done, exp_init);
    end
    repeat (3) step();
    checks++;
    if (fetch_ready !== exp_init) begin
      failures++;
      $display("FAIL reset_fetch_ready: got %b expected %b", fetch_ready, exp_init);
    end
  endtask

  task automatic test_clear_sweep();
    int cnt;
    bit early;
    reset = 1'b1;
`ifdef INST_MEM_CLEAR_EN
    cnt = 0;
    early = 1'b0;
    while (cnt < 200) begin
      step();
      cnt++;
      if (init_done === 1'b1) break;
      if (fetch_ready !== 1'b0) early = 1'b1;
    end
    checks++;
    if (cnt != DEPTH) begin
      failures++;
      $display("FAIL sweep_len: init_done after %0d cycles expected %0d", cnt, DEPTH);
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL sweep_ready: fetch_ready was 1 during clear, expected 0");
    end
    clear_model();
    drive_fetch(32'h10);
    step();
    fetch_req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL sweep_fetch_valid: got %b expected 1", inst_valid);
    end
    step();
`else
    step();
    checks++;
    if (init_done !== 1'b1 || fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL noclear_ready: init_done=%b fetch_ready=%b expected 1 1", init_done, fetch_ready);
    end
`endif
  endtask

  task automatic test_load_fetch();
    drive_load(32'h4, 32'h0050_0093);
    checks++;
    if (load_ack !== 1'b1 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load4_ack: ack=%b err=%b expected 1 0", load_ack, load_err);
    end
    drive_load(32'h8, 32'h00A0_0113);
    checks++;
    if (load_ack !== 1'b1 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load8_ack: ack=%b err=%b expected 1 0", load_ack, load_err);
    end
    drive_fetch(32'h4);
    step();
    checks++;
    if (inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_valid: got %b expected 1", inst_valid);
    end
    drive_fetch(32'h8);
    step();
    fetch_req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_valid: got %b expected 1", inst_valid);
    end
    step();
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: inst_valid=%b expected 0", inst_valid);
    end
  endtask

  task automatic test_fault();
    drive_load(32'hFC, 32'hCAFE_0001);
    checks++;
    if (load_ack !== 1'b1) begin
      failures++;
      $display("FAIL load_last_word: ack=%b expected 1", load_ack);
    end
    drive_fetch(32'hFC);
    step();
    drive_fetch(32'h6);
    step();
    drive_fetch(32'h100);
    step();
    fetch_req = 1'b0;
    step();
    checks++;
    if (inst_valid !== 1'b0 || inst_fault !== 1'b0 || inst_out !== 32'h0000_0013) begin
      failures++;
      $display("FAIL fault_hold: valid=%b fault=%b out=%h expected 0 0 00000013",
               inst_valid, inst_fault, inst_out);
    end
  endtask

  task automatic test_collision();
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'hDEAD_BEEF;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL collide_ready: got %b expected 0", fetch_ready);
    end
    step();
    load_en = 1'b0;
    fetch_req = 1'b0;
    model[0] = 32'hDEAD_BEEF;
    checks++;
    if (load_ack !== 1'b1 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_result: ack=%b valid=%b expected 1 0", load_ack, inst_valid);
    end
    drive_fetch(32'h0);
    step();
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_load_err();
    drive_load(32'h3, 32'h1234_5678);
    checks++;
    if (load_err !== 1'b1 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL load_misaligned: err=%b ack=%b expected 1 0", load_err, load_ack);
    end
    drive_load(32'h100, 32'h1234_5678);
    checks++;
    if (load_err !== 1'b1 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL load_range: err=%b ack=%b expected 1 0", load_err, load_ack);
    end
    step();
    checks++;
    if (load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_err_pulse: err=%b expected 0", load_err);
    end
    drive_fetch(32'h0);
    step();
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int cnt;
    bit bad;
    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: inst_valid=%b expected 0", inst_valid);
    end
    step();
    reset = 1'b1;
`ifdef INST_MEM_CLEAR_EN
    bad = 1'b0;
    load_en = 1'b1; load_addr = 32'h4; load_data = 32'hFFFF_FFFF;
    repeat (20) begin
      step();
      if (load_ack !== 1'b0 || load_err !== 1'b0 || inst_valid !== 1'b0 || init_done !== 1'b0) bad = 1'b1;
    end
    load_en = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL clear_ignore_load: ack/err/valid/init_done nonzero during sweep, expected 0");
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    cnt = 0;
    bad = 1'b0;
    while (cnt < 200) begin
      step();
      cnt++;
      if (inst_valid !== 1'b0) bad = 1'b1;
      if (init_done === 1'b1) break;
    end
    checks++;
    if (cnt != DEPTH || bad) begin
      failures++;
      $display("FAIL resweep: init_done after %0d cycles valid_seen=%b expected %0d 0", cnt, bad, DEPTH);
    end
    clear_model();
`else
    step();
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL noclear_reinit: init_done=%b expected 1", init_done);
    end
`endif
    drive_fetch(32'h4);
    step();
    fetch_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_load_fetch();
    test_fault();
    test_collision();
    test_load_err();
    test_reset_mid();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d results never produced, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Parametrised instruction memory with a boot-time clear sequencer, a programming (load) port and a handshaked fetch port. It sits between the PC/fetch stage and the instruction store in the single-cycle core. It replaces a fixed 64×32 array with configurable geometry, address checking and fault signalling. Instructions are written over the load port by the testbench/boot loader and read by the fetch stage with one-cycle latency.

## Interface
- DATA_WIDTH, 32, instruction word width in bits
- DEPTH, 64, number of words; power of two, ≥ 4
- ADDR_WIDTH, 32, byte-address width of fetch and load ports
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- fetch_req  input  1  fetch request, sampled when fetch_ready=1
- fetch_addr  input  ADDR_WIDTH  byte address of the instruction
- fetch_ready  output  1  fetch port can accept a request this cycle
- inst_valid  output  1  one-cycle pulse: inst_out/inst_fault valid
- inst_out  output  DATA_WIDTH  fetched instruction word
- inst_fault  output  1  accompanies inst_valid; request was misaligned or out of range
- load_en  input  1  write strobe for the programming port
- load_addr  input  ADDR_WIDTH  byte address to write
- load_data  input  DATA_WIDTH  word to write
- load_ack  output  1  one-cycle pulse, cycle after an accepted write
- load_err  output  1  one-cycle pulse, cycle after a rejected write
- init_done  output  1  high once the clear sequence has finished

## Operation
- Word index = addr >> 2. An address is legal iff addr[1:0]==0 and word index < DEPTH.
- States: CLEAR, READY.
  - reset low → CLEAR, clear counter = 0.
  - CLEAR: writes 0 to word[counter] each cycle, counter increments; on counter == DEPTH-1 the write happens and state → READY.
  - READY: normal operation; stays until reset.
- fetch_ready = (state==READY) && !load_en. Combinational from state and load_en.
- Fetch accepted when fetch_req && fetch_ready. The next cycle has inst_valid=1.
  - Legal address: inst_out = word[index], inst_fault=0.
  - Illegal address: inst_out = 32'h00000013 (NOP, zero-extended/truncated to DATA_WIDTH), inst_fault=1.
- When no fetch is accepted: inst_valid=0, inst_fault=0, inst_out holds its last value.
- Load in READY with legal load_addr: word[index] ← load_data; load_ack pulses next cycle.
- Load with illegal load_addr: no write; load_err pulses next cycle.
- Load during CLEAR: ignored, neither ack nor err.
- Load and fetch in the same cycle: load wins, fetch is not accepted (fetch_ready=0). No read-during-write hazard is possible.

## Timing
- Reset values (asynchronous assertion): state=CLEAR, counter=0, inst_valid=0, inst_fault=0, inst_out=0, load_ack=0, load_err=0, init_done=0.
- Reset affects control state only. Memory contents are cleared by the CLEAR sweep, not by reset.
- Clear sweep duration: DEPTH cycles after reset deasserts; init_done rises on the cycle after the last clear write.
- Fetch latency: 1 cycle. Back-to-back requests give inst_valid high on consecutive cycles, one result per request.
- Load latency: write visible to a fetch accepted the cycle after load_en drops.
- Reset asserted mid-sweep or mid-fetch: in-flight result discarded (inst_valid=0), sweep restarts from 0 after release.
- Counter width is clog2(DEPTH). No wrap beyond DEPTH-1.

## Configuration
- INST_MEM_CLEAR_EN defined: CLEAR state present as described.
- INST_MEM_CLEAR_EN undefined:
  - reset goes directly to READY, with init_done=1 from reset.
  - Memory content is undefined until loaded, except in simulation, where it is the initial X.
  - No clear counter is instantiated.

## Test plan
- Reset release, clear enabled, DEPTH=64 → fetch_ready=0 for 64 cycles, init_done rises on cycle 65, fetch of 0x10 returns 0x00000000, inst_fault=0.
- Load 0x00500093 @0x4, 0x00A00113 @0x8, then fetch 0x4, 0x8 back-to-back → inst_valid on two consecutive cycles, data 0x00500093 then 0x00A00113.
- Fetch 0x6 (misaligned) and 0x100 (index 64 ≥ DEPTH) → inst_valid=1, inst_fault=1, inst_out=0x00000013 each.
- load_en=1 @0x0 together with fetch_req=1 → fetch_ready=0, load_ack pulse, no inst_valid. A following fetch @0x0 returns the loaded data.
- Load @0x3 → load_err pulse, load_ack=0, word 0 unchanged.
- Assert reset mid-sweep (cycle 20) then release → sweep restarts, init_done after a further 64 cycles, inst_valid=0 throughout.
